// File: rtl/ks_multiword_adder.sv
// ks_multiword_adder: WIDTH-bit adder streaming one byte per clock through an 8-bit Kogge-Stone slice.
// Valid/ready handshakes on both sides; the carry is registered between beats.
module kogge_stone_8 (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] sum,
    output logic       cout
);
    logic [3:0][7:0] g, p;
    logic [8:0] c;
    assign g[0] = a & b;
    assign p[0] = a ^ b;
    for (genvar l = 0; l < 3; l++) begin : g_lvl
        for (genvar i = 0; i < 8; i++) begin : g_bit
            if (i >= (1 << l)) begin : g_op
                assign g[l+1][i] = g[l][i] | (p[l][i] & g[l][i-(1<<l)]);
                assign p[l+1][i] = p[l][i] & p[l][i-(1<<l)];
            end else begin : g_pass
                assign g[l+1][i] = g[l][i];
                assign p[l+1][i] = p[l][i];
            end
        end
    end
    assign c[0] = cin;
    for (genvar i = 0; i < 8; i++) begin : g_c
        assign c[i+1] = g[3][i] | (p[3][i] & cin);
    end
    assign sum  = p[0] ^ c[7:0];
    assign cout = c[8];
endmodule

module ks_multiword_adder #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int N  = WIDTH / 8;
    localparam int CW = N > 1 ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q, b_q, r_q;
    logic [CW-1:0]    cnt_q;
    logic             c_q, cout_q;
    logic [7:0]       s8;
    logic             co8;
    logic [WIDTH+7:0] r_d;

    kogge_stone_8 u_slice (.a(a_q[7:0]), .b(b_q[7:0]), .cin(c_q), .sum(s8), .cout(co8));

    // New sum byte enters at the top so byte 0 ends up at the bottom after N beats
    assign r_d = {s8, r_q};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            r_q     <= '0;
            cnt_q   <= '0;
            c_q     <= 1'b0;
            cout_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (in_valid) begin
                    a_q     <= a;
                    b_q     <= b;
                    c_q     <= cin;
                    cnt_q   <= '0;
                    state_q <= RUN;
                end
                RUN: begin
                    a_q   <= a_q >> 8;
                    b_q   <= b_q >> 8;
                    r_q   <= r_d[WIDTH+7:8];
                    c_q   <= co8;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CW'(N - 1)) begin
                        cout_q  <= co8;
                        state_q <= DONE;
                    end
                end
                DONE: if (out_ready) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = state_q == IDLE;
    assign out_valid = state_q == DONE;
    assign sum       = r_q;
    assign cout      = cout_q;
endmodule
